// File: rtl/rf_pkg.sv
// Shared defaults and types for the decode-stage register file and its
// pending-write scoreboard.
package rf_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NREAD_DEF  = 2;

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write tracker: reserve sets busy, completing write clears
// it, and pend_cnt mirrors popcount(busy) incrementally.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wv,
   input  logic [ADDR_W-1:0]      wa,
   input  logic                   rv,
   input  logic [ADDR_W-1:0]      resv_addr,
   output logic [2**ADDR_W-1:0]   busy,
   output logic [ADDR_W:0]        pend_cnt
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DEPTH-1:0] busy_nxt;
   logic             cnt_inc;
   logic             cnt_dec;

   always_comb begin
      busy_nxt = busy;
      if (wv) busy_nxt[wa] = 1'b0;
      if (rv) busy_nxt[resv_addr] = 1'b1;
      if (ZERO_REG != 0) busy_nxt[int'(REG_ZERO)] = 1'b0;
   end

   // A clear that collides with a re-reserve of the same register is net zero.
   always_comb begin
      cnt_inc = rv && !busy[resv_addr];
      cnt_dec = wv && busy[wa] && !(rv && (resv_addr == wa));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         pend_cnt <= '0;
      end else begin
         busy <= busy_nxt;
         case ({cnt_inc, cnt_dec})
            2'b10:   pend_cnt <= pend_cnt + (ADDR_W+1)'(1);
            2'b01:   pend_cnt <= pend_cnt - (ADDR_W+1)'(1);
            default: pend_cnt <= pend_cnt;
         endcase
      end
   end

endmodule

// File: rtl/rf_bypass_sb.sv
// Decode-stage register file: NREAD combinational read ports with write-to-read
// bypass, one posedge write port, and a pending-producer scoreboard.
module rf_bypass_sb
   import rf_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NREAD    = NREAD_DEF,
   parameter int ZERO_REG = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREAD*ADDR_W-1:0] rd_addr,
   output logic [NREAD*DATA_W-1:0] rd_data,
   output logic [NREAD-1:0]        rd_busy,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       wa,
   input  logic [DATA_W-1:0]       wd,
   input  logic                    resv_en,
   input  logic [ADDR_W-1:0]       resv_addr,
   output logic [ADDR_W:0]         pend_cnt
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] rf [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              wv;
   logic              rv;

   assign wv = we      && !((ZERO_REG != 0) && (wa == '0));
   assign rv = resv_en && !((ZERO_REG != 0) && (resv_addr == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < DEPTH; j++) rf[j] <= '0;
      end else if (wv) begin
         rf[wa] <= wd;
      end
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .wv        (wv),
      .wa        (wa),
      .rv        (rv),
      .resv_addr (resv_addr),
      .busy      (busy),
      .pend_cnt  (pend_cnt)
   );

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              hit_wr;
      logic              is_zero;

      assign addr    = rd_addr[i*ADDR_W +: ADDR_W];
      assign hit_wr  = wv && (wa == addr);
      assign is_zero = (ZERO_REG != 0) && (addr == '0);

      assign rd_data[i*DATA_W +: DATA_W] = is_zero ? '0 :
                                           hit_wr  ? wd : rf[addr];
      // The completing write releases its waiting readers in the same cycle.
      assign rd_busy[i] = busy[addr] && !hit_wr;
   end

endmodule

// File: tb/tb_rf_bypass_sb.sv
// Directed bench for rf_bypass_sb: vector table of per-cycle stimulus with
// hand-computed expectations, plus reset-related sequences.
module tb_rf_bypass_sb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_busy;
   logic             we;
   logic [AW-1:0]    wa;
   logic [DW-1:0]    wd;
   logic             resv_en;
   logic [AW-1:0]    resv_addr;
   logic [AW:0]      pend_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   rf_bypass_sb #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .we        (we),
      .wa        (wa),
      .wd        (wd),
      .resv_en   (resv_en),
      .resv_addr (resv_addr),
      .pend_cnt  (pend_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          re;
      logic [AW-1:0] ra;
      logic [AW-1:0] r0;
      logic [AW-1:0] r1;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic [1:0]    b;
      logic [AW:0]   cnt;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vt [NVEC];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic r, input logic [AW-1:0] ra,
                        input logic [AW-1:0] p0, input logic [AW-1:0] p1);
      we        = w;
      wa        = a;
      wd        = d;
      resv_en   = r;
      resv_addr = ra;
      rd_addr   = {p1, p0};
   endtask

   initial begin
      //           we  wa  wd            re  ra   r0  r1  d0            d1            b      cnt
      vt[0]  = '{1'b1, 5,  32'hDEADBEEF, 1'b0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        2'b00, 0};
      vt[1]  = '{1'b0, 0,  32'h0,        1'b0, 0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0};
      vt[2]  = '{1'b1, 0,  32'h1234,     1'b0, 0,  0,  5,  32'h0,        32'hDEADBEEF, 2'b00, 0};
      vt[3]  = '{1'b0, 0,  32'h0,        1'b1, 0,  0,  5,  32'h0,        32'hDEADBEEF, 2'b00, 0};
      vt[4]  = '{1'b0, 0,  32'h0,        1'b0, 0,  0,  0,  32'h0,        32'h0,        2'b00, 0};
      vt[5]  = '{1'b0, 0,  32'h0,        1'b1, 8,  8,  0,  32'h0,        32'h0,        2'b00, 0};
      vt[6]  = '{1'b0, 0,  32'h0,        1'b0, 0,  8,  8,  32'h0,        32'h0,        2'b11, 1};
      vt[7]  = '{1'b1, 8,  32'h55,       1'b0, 0,  8,  5,  32'h55,       32'hDEADBEEF, 2'b00, 1};
      vt[8]  = '{1'b0, 0,  32'h0,        1'b0, 0,  8,  0,  32'h55,       32'h0,        2'b00, 0};
      vt[9]  = '{1'b0, 0,  32'h0,        1'b1, 3,  3,  0,  32'h0,        32'h0,        2'b00, 0};
      vt[10] = '{1'b1, 3,  32'h77,       1'b1, 3,  3,  8,  32'h77,       32'h55,       2'b00, 1};
      vt[11] = '{1'b0, 0,  32'h0,        1'b1, 3,  3,  0,  32'h77,       32'h0,        2'b01, 1};
      vt[12] = '{1'b0, 0,  32'h0,        1'b0, 0,  3,  3,  32'h77,       32'h77,       2'b11, 1};
      vt[13] = '{1'b1, 3,  32'h99,       1'b0, 0,  3,  3,  32'h99,       32'h99,       2'b00, 1};
      vt[14] = '{1'b0, 0,  32'h0,        1'b0, 0,  3,  0,  32'h99,       32'h0,        2'b00, 0};
      vt[15] = '{1'b1, 5,  32'hA5,       1'b1, 10, 5,  10, 32'hA5,       32'h0,        2'b00, 0};
      vt[16] = '{1'b1, 10, 32'hB0,       1'b1, 11, 10, 11, 32'hB0,       32'h0,        2'b00, 1};
      vt[17] = '{1'b0, 0,  32'h0,        1'b0, 0,  10, 11, 32'hB0,       32'h0,        2'b10, 1};
      vt[18] = '{1'b1, 11, 32'h1,        1'b0, 0,  11, 31, 32'h1,        32'h0,        2'b00, 1};
      vt[19] = '{1'b0, 0,  32'h0,        1'b0, 0,  11, 0,  32'h1,        32'h0,        2'b00, 0};

      rst_n = 1'b0;
      drive(1'b0, 0, 0, 1'b0, 0, 0, 0);
      #12 rst_n = 1'b1;

      for (int a = 0; a < 32; a++) begin
         rd_addr = {AW'(31 - a), AW'(a)};
         #1;
         chk($sformatf("rst_rd0[%0d]", a), 64'(rd_data[DW-1:0]), 64'h0);
         chk($sformatf("rst_rd1[%0d]", 31 - a), 64'(rd_data[2*DW-1:DW]), 64'h0);
         chk($sformatf("rst_busy[%0d]", a), 64'(rd_busy), 64'h0);
      end
      chk("rst_cnt", 64'(pend_cnt), 64'h0);

      @(posedge clk); #1;
      for (int v = 0; v < NVEC; v++) begin
         drive(vt[v].we, vt[v].wa, vt[v].wd, vt[v].re, vt[v].ra, vt[v].r0, vt[v].r1);
         #3;
         chk($sformatf("v%0d_d0", v), 64'(rd_data[DW-1:0]), 64'(vt[v].d0));
         chk($sformatf("v%0d_d1", v), 64'(rd_data[2*DW-1:DW]), 64'(vt[v].d1));
         chk($sformatf("v%0d_busy", v), 64'(rd_busy), 64'(vt[v].b));
         chk($sformatf("v%0d_cnt", v), 64'(pend_cnt), 64'(vt[v].cnt));
         @(posedge clk); #1;
      end

      // Reserve 1, 2, 4 then drop reset mid-cycle.
      drive(1'b0, 0, 0, 1'b1, 1, 0, 0);
      @(posedge clk); #1;
      drive(1'b0, 0, 0, 1'b1, 2, 0, 0);
      @(posedge clk); #1;
      drive(1'b0, 0, 0, 1'b1, 4, 0, 0);
      @(posedge clk); #1;
      drive(1'b0, 0, 0, 1'b0, 0, 1, 4);
      #1;
      chk("pre_rst_cnt", 64'(pend_cnt), 64'd3);
      chk("pre_rst_busy", 64'(rd_busy), 64'b11);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_cnt", 64'(pend_cnt), 64'd0);
      chk("mid_rst_busy", 64'(rd_busy), 64'b00);
      rd_addr = {AW'(8), AW'(5)};
      #1;
      chk("mid_rst_d5", 64'(rd_data[DW-1:0]), 64'h0);
      chk("mid_rst_d8", 64'(rd_data[2*DW-1:DW]), 64'h0);
      drive(1'b1, 7, 32'h3C, 1'b0, 0, 7, 2);
      #1;
      chk("rst_bypass_d", 64'(rd_data[DW-1:0]), 64'h3C);
      chk("rst_busy2", 64'(rd_busy), 64'b00);
      drive(1'b0, 0, 0, 1'b0, 0, 7, 0);
      @(posedge clk); #1;
      chk("rst_no_write", 64'(rd_data[DW-1:0]), 64'h0);
      #2 rst_n = 1'b1;
      drive(1'b1, 9, 32'h42, 1'b0, 0, 9, 7);
      @(posedge clk); #1;
      drive(1'b0, 0, 0, 1'b0, 0, 9, 7);
      #1;
      chk("post_rst_wr9", 64'(rd_data[DW-1:0]), 64'h42);
      chk("post_rst_d7", 64'(rd_data[2*DW-1:DW]), 64'h0);
      chk("post_rst_cnt", 64'(pend_cnt), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_bypass_sb.md
# rf_bypass_sb

Parametrised general-purpose register file for the pipelined MIPS core: N combinational read ports, one write port, and a posedge write with same-cycle write-to-read bypass. It also holds a per-register pending-write scoreboard that the hazard unit uses to stall on outstanding producers (loads, multi-cycle ops). It sits in the decode stage; write-back drives the write port.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits.
- `ADDR_W`, 5, address width; depth = 2**ADDR_W.
- `NREAD`, 2, number of read ports (≥1).
- `ZERO_REG`, 1, when 1, register 0 reads 0, ignores writes and is never busy.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rd_addr`  in  NREAD*ADDR_W  read addresses; port i is `[i*ADDR_W +: ADDR_W]`.
- `rd_data`  out  NREAD*DATA_W  read data, same packing.
- `rd_busy`  out  NREAD  1 = register at port i has a pending producer; data not yet valid.
- `we`  in  1  write enable.
- `wa`  in  ADDR_W  write address.
- `wd`  in  DATA_W  write data.
- `resv_en`  in  1  reserve `resv_addr` as pending (issued producer).
- `resv_addr`  in  ADDR_W  register to reserve.
- `pend_cnt`  out  ADDR_W+1  number of registers currently busy.

## Operation
- Effective write: `wv = we && !(ZERO_REG && wa==0)`. Effective reserve: `rv = resv_en && !(ZERO_REG && resv_addr==0)`.
- Storage: on posedge, if `wv`, set `RF[wa] <= wd`. Contents are undefined-free: all entries are zero after reset, and there is no file preload.
- Read port i (combinational):
  - If `ZERO_REG` and address 0, the port returns 0.
  - Else if `wv && wa==rd_addr[i]`, the port returns `wd` (bypass).
  - Else the port returns `RF[rd_addr[i]]`.
- `rd_busy[i] = busy[rd_addr[i]] && !(wv && wa==rd_addr[i])`. A completing write releases the reader in the same cycle.
- Scoreboard update on posedge: the write clears `busy[wa]` if `wv`; the reserve sets `busy[resv_addr]` if `rv`. When both target the same register, set wins and the register stays busy for the new producer.
- Reserving an already-busy register leaves it busy and does not change the count.
- Writing a non-busy register is legal and leaves the scoreboard unchanged.
- `pend_cnt` is registered and always equals popcount(busy). Per cycle it moves by −1, 0 or +1, derived from the pre-edge busy bits of `wa` and `resv_addr`:
  - `rv` on a register that is not busy adds 1.
  - `wv` on a busy register adds −1.
  - Set and clear on the same busy register is net 0.
- Reads on multiple ports may alias the same address and the write address freely.

## Timing
- Read latency is 0 cycles (combinational from `rd_addr`, `wa`, `wd`, `we`). Write is visible via the array at the first cycle after the edge, and via bypass in the same cycle.
- Reserve becomes visible on `rd_busy` one cycle after the `resv_en` edge.
- Reset asserted (any time, including mid-cycle): all RF entries go to 0, busy to 0 and `pend_cnt` to 0 immediately. Reset release is synchronised externally; the first write is accepted on the first posedge with `rst_n` high.
- Outputs during reset: `rd_data` = 0 for all addresses; `rd_busy` = 0, except that bypass of a concurrent `we` still applies combinationally. `pend_cnt` = 0.
- There is no handshake; the hazard unit must stall the reader while `rd_busy[i]`=1.

## Structure
- Package `rf_pkg`:
  - default `DATA_W`/`ADDR_W`/`NREAD` localparams;
  - a `reg_addr_t` typedef;
  - the `REG_ZERO` constant.
- Sub-module `rf_scoreboard` (params `ADDR_W`, `ZERO_REG`) holds the busy vector and `pend_cnt`, with inputs `wv`/`wa`/`rv`/`resv_addr`.
- The top level holds the data array, the bypass muxes and a generate loop over `NREAD` ports.

## Test plan
- Reset then read all 32 addresses on both ports -> every `rd_data`=0, `rd_busy`=0, `pend_cnt`=0.
- Write `wa`=5 `wd`=0xDEADBEEF with `rd_addr[0]`=5 in the same cycle -> `rd_data[0]`=0xDEADBEEF in that cycle, and still 0xDEADBEEF the next cycle with `we`=0.
- Write `wa`=0 `wd`=0x1234 with `ZERO_REG`=1, then read address 0 -> 0. `resv_en` on 0 -> `pend_cnt` stays 0.
- Reserve 8, next cycle read 8 -> `rd_busy`=1, `pend_cnt`=1. Write 8 = 0x55 -> same cycle `rd_busy`=0 and `rd_data`=0x55; next cycle `pend_cnt`=0.
- Reserve 3 and write 3 in the same cycle while 3 is busy -> 3 remains busy and `pend_cnt` is unchanged. Reserve 3 again -> `pend_cnt` is unchanged.
- Reserve 1, 2 and 4, then assert `rst_n`=0 mid-cycle -> `pend_cnt`, busy and all registers clear immediately without waiting for a clock.
